// File: rtl/act_pkg.sv
// ============================================================================
//  Module   : act_pkg
//  Purpose  : Shared types and FP16 constants for the vector activation unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package act_pkg;

    // Raw IEEE-754 half-precision word
    typedef logic [15:0] fp16_t;

    // Activation selector, carried with every beat
    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_RELU6  = 2'd3
    } act_mode_e;

    localparam fp16_t FP16_ZERO = 16'h0000;
    localparam fp16_t FP16_SIX  = 16'h4600;
    localparam fp16_t FP16_QNAN = 16'h7E00;

    // True for any NaN encoding, either sign
    function automatic logic fp16_is_nan(input fp16_t x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/act_lane.sv
// ============================================================================
//  Module   : act_lane
//  Purpose  : Single-lane combinational FP16 activation (bypass, ReLU,
//             leaky ReLU with power-of-two slope, ReLU6).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_lane
    import act_pkg::*;
#(
    parameter int LEAK_SHIFT = 3
) (
    input  logic [15:0] x_i,
    input  act_mode_e   mode_i,
    output logic [15:0] z_o
);

    localparam logic [4:0] SHIFT5 = 5'(LEAK_SHIFT);

    logic       sgn;
    logic [4:0] expo;
    logic [9:0] man;
    logic       is_nan;

    assign sgn    = x_i[15];
    assign expo   = x_i[14:10];
    assign man    = x_i[9:0];
    assign is_nan = fp16_is_nan(x_i);

    // Select the per-mode result; the leaky exponent subtract only happens
    // above the flush threshold, so the 5-bit difference never wraps.
    always_comb begin
        z_o = x_i;
        case (mode_i)
            ACT_BYPASS: z_o = x_i;
            ACT_RELU: begin
                if (sgn) z_o = FP16_ZERO;
            end
            ACT_LEAKY: begin
                if (sgn) begin
                    if (expo == 5'h1F)        z_o = x_i;
                    else if (expo <= SHIFT5)  z_o = FP16_ZERO;
                    else                      z_o = {1'b1, expo - SHIFT5, man};
                end
            end
            ACT_RELU6: begin
                if (is_nan)                        z_o = FP16_QNAN;
                else if (sgn)                      z_o = FP16_ZERO;
                else if (x_i[14:0] > FP16_SIX[14:0]) z_o = FP16_SIX;
            end
            default: z_o = x_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/act_vec_pipe.sv
// ============================================================================
//  Module   : act_vec_pipe
//  Purpose  : Two-stage valid/ready pipelined multi-lane FP16 activation unit.
//             S1 registers raw lanes/mode/last, S2 registers the result.
//  Option   : ACT_SPARSITY_CNT_EN adds the saturating zero-lane counter
//             (zero_cnt output, cnt_clr input).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_vec_pipe
    import act_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*16-1:0]  in_data,
    input  logic [1:0]           in_mode,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*16-1:0]  out_data,
    output logic                 out_last
`ifdef ACT_SPARSITY_CNT_EN
    ,
    output logic [CNT_W-1:0]     zero_cnt,
    input  logic                 cnt_clr
`endif
);

    localparam int DW = LANES * 16;

    if (LANES < 1 || LANES > 64 || LEAK_SHIFT < 1 || LEAK_SHIFT > 14 || CNT_W < 1) begin : g_bad_params
        $error("act_vec_pipe: parameter out of range");
    end

    logic          s1_valid_q;
    logic [DW-1:0] s1_data_q;
    act_mode_e     s1_mode_q;
    logic          s1_last_q;

    logic          s2_valid_q;
    logic [DW-1:0] s2_data_q;
    logic [DW-1:0] s2_data_d;
    logic          s2_last_q;

    logic          adv1;
    logic          adv2;

    // A stage may load when it is empty or its content moves on this cycle
    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_last  = s2_last_q;

    // S1: capture the raw beat together with its mode and end-of-tile flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= ACT_BYPASS;
            s1_last_q  <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_data;
                s1_mode_q <= act_mode_e'(in_mode);
                s1_last_q <= in_last;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        act_lane #(
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x_i    (s1_data_q[16*k +: 16]),
            .mode_i (s1_mode_q),
            .z_o    (s2_data_d[16*k +: 16])
        );
    end

    // S2: register the activated lanes; holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
                s2_last_q <= s1_last_q;
            end
        end
    end

`ifdef ACT_SPARSITY_CNT_EN
    localparam int ZW    = $clog2(LANES + 1);
    localparam int SUM_W = CNT_W + ZW;

    logic [ZW-1:0]    zeros_w;
    logic [SUM_W-1:0] sum_w;
    logic [CNT_W-1:0] zero_cnt_d;
    logic [CNT_W-1:0] zero_cnt_q;

    // Count output lanes that are exactly +0 in the current S2 beat
    always_comb begin
        zeros_w = '0;
        for (int k = 0; k < LANES; k++) begin
            if (s2_data_q[16*k +: 16] == FP16_ZERO) zeros_w = zeros_w + ZW'(1);
        end
    end

    // Next count: clear wins, else saturating add on an output handshake
    always_comb begin
        sum_w      = SUM_W'(zero_cnt_q) + SUM_W'(zeros_w);
        zero_cnt_d = zero_cnt_q;
        if (cnt_clr) begin
            zero_cnt_d = '0;
        end else if (s2_valid_q && out_ready) begin
            if (sum_w > SUM_W'({CNT_W{1'b1}})) zero_cnt_d = '1;
            else                               zero_cnt_d = sum_w[CNT_W-1:0];
        end
    end

    // Sparsity counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero_cnt_q <= '0;
        else        zero_cnt_q <= zero_cnt_d;
    end

    assign zero_cnt = zero_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_act_vec_pipe.sv
// ============================================================================
//  Module   : tb_act_vec_pipe
//  Purpose  : Directed self-checking bench for act_vec_pipe (LANES=4,
//             LEAK_SHIFT=3, default build without ACT_SPARSITY_CNT_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_act_vec_pipe;

    localparam int LANES = 4;
    localparam int DW    = LANES * 16;
    localparam int NV    = 9;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_mode;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] vin  [0:NV-1];
    logic [1:0]    vmd  [0:NV-1];
    logic [DW-1:0] vexp [0:NV-1];

    act_vec_pipe #(
        .LANES      (LANES),
        .LEAK_SHIFT (3),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        in_valid = 1'b1;
        in_data  = vin[i];
        in_mode  = vmd[i];
        in_last  = 1'(i % 2);
    endtask

    initial begin
        int iidx;
        int oidx;
        int occ;
        int cyc;
        int wait_cnt;
        logic in_hs;
        logic out_hs;
        logic [31:0] pat;

        // lanes written {lane3, lane2, lane1, lane0}
        vin[0] = 64'h7E00_8000_BC00_3C00; vmd[0] = 2'd1; vexp[0] = 64'h7E00_0000_0000_3C00;
        vin[1] = 64'hFC00_8200_8C00_C000; vmd[1] = 2'd2; vexp[1] = 64'hFC00_0000_0000_B400;
        vin[2] = 64'hFE00_7C00_4500_4700; vmd[2] = 2'd3; vexp[2] = 64'h7E00_4600_4500_4600;
        vin[3] = 64'h8000_FC00_1234_7E01; vmd[3] = 2'd0; vexp[3] = 64'h8000_FC00_1234_7E01;
        vin[4] = 64'hFE01_8000_3C00_9000; vmd[4] = 2'd2; vexp[4] = 64'hFE01_0000_3C00_8400;
        vin[5] = 64'h7C01_8000_4601_4600; vmd[5] = 2'd3; vexp[5] = 64'h7E00_0000_4600_4600;
        vin[6] = 64'hFBFF_0001_FE01_7E01; vmd[6] = 2'd1; vexp[6] = 64'h0000_0001_0000_7E01;
        vin[7] = 64'h4600_C000_3C00_0000; vmd[7] = 2'd1; vexp[7] = 64'h4600_0000_3C00_0000;
        vin[8] = 64'h3555_8400_C400_7C00; vmd[8] = 2'd2; vexp[8] = 64'h3555_0000_B800_7C00;

        // ---- reset state ----
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_out_data",  out_data, '0);
        chk("rst_out_last",  DW'(out_last), DW'(0));
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", DW'(in_ready), DW'(1));

        // ---- back-to-back ReLU / leaky / ReLU6, out_ready=1 ----
        drive(0);
        step();                                   // beat 0 accepted
        drive(1);
        chk("lat_not_yet", DW'(out_valid), DW'(0));
        step();                                   // beat 1 accepted
        drive(2);
        chk("lat2_valid", DW'(out_valid), DW'(1));
        chk("relu_data",  out_data, vexp[0]);
        chk("relu_last",  DW'(out_last), DW'(0));
        step();                                   // beat 2 accepted
        in_valid = 1'b0;
        chk("leaky_valid", DW'(out_valid), DW'(1));
        chk("leaky_data",  out_data, vexp[1]);
        chk("leaky_last",  DW'(out_last), DW'(1));
        step();
        chk("relu6_valid", DW'(out_valid), DW'(1));
        chk("relu6_data",  out_data, vexp[2]);
        chk("relu6_last",  DW'(out_last), DW'(0));
        step();
        chk("drain_valid", DW'(out_valid), DW'(0));

        // ---- back-pressure: beats 3..8, mixed modes, out_ready pattern ----
        pat  = 32'b0110_1001_1100_0101_0011_1000_0100_1100;
        iidx = 3;
        oidx = 3;
        occ  = 0;
        cyc  = 0;
        while (oidx < NV && cyc < 200) begin
            out_ready = pat[cyc % 32];
            if (iidx < NV) drive(iidx);
            else           in_valid = 1'b0;
            @(negedge clk);
            chk("bp_in_ready", DW'(in_ready), DW'(!(occ == 2 && !out_ready)));
            in_hs  = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (out_hs) begin
                chk("bp_data", out_data, vexp[oidx]);
                chk("bp_last", DW'(out_last), DW'(oidx % 2));
            end
            step();
            if (in_hs)  begin iidx++; occ++; end
            if (out_hs) begin oidx++; occ--; end
            cyc++;
        end
        chk("bp_all_out", DW'(oidx), DW'(NV));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_no_dup", DW'(out_valid), DW'(0));

        // ---- reset with two beats in flight ----
        drive(0);
        step();
        drive(1);
        step();
        in_valid = 1'b0;
        chk("inflight_valid", DW'(out_valid), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", DW'(out_valid), DW'(0));
        chk("async_rst_data",  out_data, '0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_empty", DW'(out_valid), DW'(0));
        drive(7);
        step();
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 10) begin
            step();
            wait_cnt++;
        end
        chk("post_rst_latency", DW'(wait_cnt), DW'(1));
        chk("post_rst_data",    out_data, vexp[7]);
        chk("post_rst_last",    DW'(out_last), DW'(1));
        step();
        chk("post_rst_single", DW'(out_valid), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
